// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single-precision divider, y = x1 / x2.
// Restoring division produces one quotient bit per clock. The request
// side and the response side each use a valid/ready handshake.
// Subnormal inputs are flushed to zero. Underflowing results flush to
// signed zero. Results round to nearest, ties to even.
//
// Ports:
//   clk, rstn             clock; asynchronous active-low reset
//   x1, x2                dividend and divisor (IEEE single)
//   req_valid, req_ready  request handshake; req_ready is high only in IDLE
//   y                     quotient, held stable while resp_valid is high
//   ovf                   a finite/finite result overflowed to infinity
//   dz                    finite nonzero divided by zero
//   resp_valid, resp_ready  response handshake
module fdiv_seq #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        dz,
    output logic        resp_valid,
    input  logic        resp_ready
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } fp32_t;

    state_t                state;
    logic [24:0]           r;        // partial remainder, always < 2*d
    logic [23:0]           d;        // divisor significand with hidden one
    logic [QBITS-1:0]      q;        // quotient, filled MSB first
    logic [4:0]            count;
    logic signed [9:0]     expo;     // wide enough that e1-e2+127 cannot wrap
    logic                  sign;

    fp32_t a, b;
    assign a = x1;
    assign b = x2;

    // ------------------------------------------------------------------
    // Operand classification and special-case results (IDLE only)
    // ------------------------------------------------------------------
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        sp_hit, sp_dz;
    logic [31:0] sp_y;
    logic        s_xor;
    logic signed [9:0] exp_diff;

    assign nan_a  = (a.e == 8'hFF) && (a.m != 23'd0);
    assign nan_b  = (b.e == 8'hFF) && (b.m != 23'd0);
    assign inf_a  = (a.e == 8'hFF) && (a.m == 23'd0);
    assign inf_b  = (b.e == 8'hFF) && (b.m == 23'd0);
    // A zero exponent also covers subnormals, which are flushed to zero.
    assign zero_a = (a.e == 8'h00);
    assign zero_b = (b.e == 8'h00);
    assign s_xor  = a.s ^ b.s;
    assign exp_diff = $signed({2'b00, a.e}) - $signed({2'b00, b.e}) + 10'sd127;

    always_comb begin
        sp_hit = 1'b1;
        sp_dz  = 1'b0;
        sp_y   = 32'd0;
        if (nan_a) begin
            // Propagate the first NaN operand and force it quiet.
            sp_y = {a.s, 8'hFF, 1'b1, a.m[21:0]};
        end else if (nan_b) begin
            sp_y = {b.s, 8'hFF, 1'b1, b.m[21:0]};
        end else if ((inf_a && inf_b) || (zero_a && zero_b)) begin
            sp_y = 32'h7FC0_0000;
        end else if (inf_a) begin
            sp_y = {s_xor, 8'hFF, 23'd0};
        end else if (inf_b) begin
            sp_y = {s_xor, 8'h00, 23'd0};
        end else if (zero_b) begin
            sp_y  = {s_xor, 8'hFF, 23'd0};
            sp_dz = 1'b1;
        end else if (zero_a) begin
            sp_y = {s_xor, 8'h00, 23'd0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic        ge;
    logic [23:0] diff;
    logic [24:0] r_nxt;

    assign ge   = (r >= {1'b0, d});
    // When r >= d, r - d < d < 2^24, so 24 bits hold the difference exactly.
    assign diff = r[23:0] - d;
    assign r_nxt = ge ? {diff, 1'b0} : {r[23:0], 1'b0};

    // ------------------------------------------------------------------
    // Normalise and round (NORM)
    // ------------------------------------------------------------------
    logic [22:0]       frac;
    logic              g, st, inc;
    logic signed [9:0] ex_n;
    logic [32:0]       packed_r;
    logic signed [9:0] ex_r;
    logic [31:0]       n_y;
    logic              n_ovf;

    always_comb begin
        if (q[QBITS-1]) begin
            frac = q[24:2];
            g    = q[1];
            st   = q[0] | (r != 25'd0);
            ex_n = expo;
        end else begin
            frac = q[23:1];
            g    = q[0];
            st   = (r != 25'd0);
            ex_n = expo - 10'sd1;
        end
        inc = g & (st | frac[0]);
        // The exponent sits directly above the fraction, so a carry out of
        // an all-ones fraction moves into the exponent on its own.
        packed_r = {ex_n, frac} + {32'd0, inc};
        ex_r     = $signed(packed_r[32:23]);
        n_ovf    = 1'b0;
        if (ex_r >= 10'sd255) begin
            n_y   = {sign, 8'hFF, 23'd0};
            n_ovf = 1'b1;
        end else if (ex_r <= 10'sd0) begin
            n_y = {sign, 8'h00, 23'd0};
        end else begin
            n_y = {sign, ex_r[7:0], packed_r[22:0]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            y          <= 32'd0;
            ovf        <= 1'b0;
            dz         <= 1'b0;
            r          <= 25'd0;
            d          <= 24'd0;
            q          <= '0;
            count      <= 5'd0;
            expo       <= 10'sd0;
            sign       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        sign      <= s_xor;
                        if (sp_hit) begin
                            y          <= sp_y;
                            ovf        <= 1'b0;
                            dz         <= sp_dz;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            r     <= {2'b01, a.m};
                            d     <= {1'b1, b.m};
                            q     <= '0;
                            count <= 5'd0;
                            expo  <= exp_diff;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    r     <= r_nxt;
                    q     <= {q[QBITS-2:0], ge};
                    count <= count + 5'd1;
                    if (count == 5'(QBITS - 1))
                        state <= NORM;
                end
                NORM: begin
                    y          <= n_y;
                    ovf        <= n_ovf;
                    dz         <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed test of fdiv_seq. Every expected value below was computed by hand.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1 = 32'd0, x2 = 32'd0;
    logic        req_valid = 1'b0, resp_ready = 1'b0;
    logic        req_ready, ovf, dz, resp_valid;
    logic [31:0] y;

    int total = 0;
    int bad   = 0;

    fdiv_seq dut (
        .clk(clk), .rstn(rstn), .x1(x1), .x2(x2),
        .req_valid(req_valid), .req_ready(req_ready),
        .y(y), .ovf(ovf), .dz(dz),
        .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the response, check it, optionally stall
    // the response for some cycles, then complete the handshake.
    task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic eovf, input logic edz,
                       input int elat, input int hold);
        int lat;
        @(negedge clk);
        chk({nm, ".rdy"}, {31'd0, req_ready}, 32'd1);
        x1 = a; x2 = b; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".lat"}, lat, elat);
        chk({nm, ".y"}, y, ey);
        chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
        chk({nm, ".dz"}, {31'd0, dz}, {31'd0, edz});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold_y"}, y, ey);
            chk({nm, ".hold_rdy"}, {31'd0, req_ready}, 32'd0);
            chk({nm, ".hold_vld"}, {31'd0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, ".vld_clr"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, ".flags_hold"}, {30'd0, ovf, dz}, {30'd0, eovf, edz});
    endtask

    initial begin
        int acc[2];
        int hs[2];
        logic [31:0] hy[2];
        int nacc, nhs;
        bit sw;

        // Reset state
        #2;
        chk("rst.y", y, 32'd0);
        chk("rst.vld", {31'd0, resp_valid}, 32'd0);
        chk("rst.flags", {30'd0, ovf, dz}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst.rdy", {31'd0, req_ready}, 32'd1);

        // Normal path and specials
        run("6div2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 28, 5);
        run("1div3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0, 0, 28, 0);
        run("1div1",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 28, 0);
        run("m1div0",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0, 1, 1, 0);
        run("0div0",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 0, 1, 0);
        run("infinf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0, 0, 1, 0);
        run("nan1",    32'h7FC1_2345, 32'h3F80_0000, 32'h7FC1_2345, 0, 0, 1, 0);
        run("nan2",    32'h3F80_0000, 32'hFF81_2345, 32'hFFC1_2345, 0, 0, 1, 0);
        run("infdivm2",32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 0, 0, 1, 0);
        run("1divminf",32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 0, 0, 1, 0);
        run("0div2",   32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 1, 0);
        run("ovf",     32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1, 0, 28, 0);
        run("uflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 28, 0);

        // Back-to-back with req_valid held and resp_ready high
        @(negedge clk);
        x1 = 32'h40C0_0000; x2 = 32'h4000_0000;
        req_valid = 1'b1; resp_ready = 1'b1;
        nacc = 0; nhs = 0; sw = 1'b0;
        acc[0] = 0; acc[1] = 0; hs[0] = 0; hs[1] = 0; hy[0] = 0; hy[1] = 0;
        for (int c = 0; c < 120 && nhs < 2; c++) begin
            if (nacc == 1 && !sw) begin
                x1 = 32'h3F80_0000; x2 = 32'h4040_0000; sw = 1'b1;
            end
            if (nacc == 2) req_valid = 1'b0;
            if (req_valid && req_ready && nacc < 2) begin
                acc[nacc] = c; nacc++;
            end
            if (resp_valid && resp_ready && nhs < 2) begin
                hs[nhs] = c; hy[nhs] = y; nhs++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("b2b.nresp", nhs, 2);
        chk("b2b.y0", hy[0], 32'h4040_0000);
        chk("b2b.y1", hy[1], 32'h3EAA_AAAB);
        chk("b2b.lat0", hs[0] - acc[0], 28);
        chk("b2b.acc1", acc[1], hs[0] + 1);

        // Reset in the middle of a division
        @(negedge clk);
        x1 = 32'h40C0_0000; x2 = 32'h4000_0000; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst.vld", {31'd0, resp_valid}, 32'd0);
        chk("midrst.y", y, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst.rdy", {31'd0, req_ready}, 32'd1);
        repeat (30) @(negedge clk);
        chk("midrst.noresp", {31'd0, resp_valid}, 32'd0);
        run("post_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 28, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
